// File: rtl/rect_fill_engine_if.sv
// Framebuffer write port between the rectangle fill engine and the pixel memory.
// The engine drives the write fields and the memory answers with fb_ready.
interface rect_fill_engine_if;
  logic       fb_we;
  logic [8:0] fb_x;
  logic [7:0] fb_y;
  logic       fb_data;
  logic       fb_ready;

  modport master (
    output fb_we,
    output fb_x,
    output fb_y,
    output fb_data,
    input  fb_ready
  );

  modport slave (
    input  fb_we,
    input  fb_x,
    input  fb_y,
    input  fb_data,
    output fb_ready
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: bounds-checks a latched command, then writes every pixel of the
// rectangle in raster order (x fastest) through a ready-gated framebuffer port.
module rect_fill_engine #(
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_fill,
  input  logic [8:0]                 X1,
  input  logic [7:0]                 Y1,
  input  logic [8:0]                 op_width,
  input  logic [7:0]                 op_height,
  input  logic                       fill_value,
  rect_fill_engine_if.master         fb,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  typedef enum logic [1:0] {StIdle, StCheck, StFill, StFinish} state_e;

  state_e     r_state;
  state_e     w_state_nxt;

  logic [8:0] r_x1;
  logic [7:0] r_y1;
  logic [8:0] r_w;
  logic [7:0] r_h;
  logic       r_val;
  logic [8:0] r_cur_x;
  logic [7:0] r_cur_y;

  logic [9:0] w_x_sum;
  logic [8:0] w_y_sum;
  logic       w_zero;
  logic       w_oob;
  logic       w_last_x;
  logic       w_last_y;
  logic       w_we;
  logic       w_accept;

  // Sums are one bit wider than the operands so that overflow reads as out of bounds.
  assign w_x_sum  = {1'b0, r_x1} + {1'b0, r_w};
  assign w_y_sum  = {1'b0, r_y1} + {1'b0, r_h};
  assign w_zero   = (r_w == 9'd0) || (r_h == 8'd0);
  assign w_oob    = (w_x_sum > 10'(SCREEN_W)) || (w_y_sum > 9'(SCREEN_H));
  assign w_last_x = (r_cur_x == (r_x1 + r_w - 9'd1));
  assign w_last_y = (r_cur_y == (r_y1 + r_h - 8'd1));

  // Outputs are forced quiet while reset is held, even before the state register clears.
  assign w_we     = (r_state == StFill) && !reset;
  assign w_accept = w_we && fb.fb_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_x1    <= '0;
      r_y1    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_val   <= 1'b0;
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == StIdle) && start_fill) begin
        r_x1  <= X1;
        r_y1  <= Y1;
        r_w   <= op_width;
        r_h   <= op_height;
        r_val <= fill_value;
      end
      if (r_state == StCheck) begin
        r_cur_x <= r_x1;
        r_cur_y <= r_y1;
      end else if (w_accept) begin
        if (w_last_x) begin
          r_cur_x <= r_x1;
          r_cur_y <= r_cur_y + 8'd1;
        end else begin
          r_cur_x <= r_cur_x + 9'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    error       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_fill) w_state_nxt = StCheck;
      end
      StCheck: begin
        if (w_zero) begin
          w_state_nxt = StFinish;
        end else if (w_oob) begin
          error       = !reset;
          w_state_nxt = StIdle;
        end else begin
          w_state_nxt = StFill;
        end
      end
      StFill: begin
        if (w_accept && w_last_x && w_last_y) w_state_nxt = StFinish;
      end
      StFinish: begin
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    fb.fb_we   = w_we;
    fb.fb_x    = reset ? 9'd0 : r_cur_x;
    fb.fb_y    = reset ? 8'd0 : r_cur_y;
    fb.fb_data = reset ? 1'b0 : r_val;
    busy       = (r_state != StIdle) && !reset;
    done       = (r_state == StFinish) && !reset;
  end

endmodule

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
Parameters:
REQ-001 The block SHALL have parameter SCREEN_W, default 320, visible framebuffer width in pixels.
REQ-002 The block SHALL have parameter SCREEN_H, default 200, visible framebuffer height in pixels.

Ports:
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_fill  input  1  one-cycle command strobe from the EPP register stage.
REQ-006 X1  input  9  rectangle left column.
REQ-007 Y1  input  8  rectangle top row.
REQ-008 op_width  input  9  rectangle width in pixels.
REQ-009 op_height  input  8  rectangle height in pixels.
REQ-010 fill_value  input  1  pixel value to write.
REQ-011 fb_ready  input  1  framebuffer port accepts a write this cycle.
REQ-012 fb_we  output  1  write request, valid with fb_x/fb_y/fb_data.
REQ-013 fb_x  output  9  write column.
REQ-014 fb_y  output  8  write row.
REQ-015 fb_data  output  1  write pixel value.
REQ-016 busy  output  1  high while a command is in progress.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 error  output  1  one-cycle pulse on a rejected command.

Function
REQ-019 States SHALL be IDLE, CHECK, FILL and FINISH.
REQ-020 In IDLE, start_fill SHALL latch X1, Y1, op_width, op_height and fill_value, then go to CHECK.
REQ-021 While not IDLE, busy SHALL be 1; start_fill SHALL be ignored with no side effects.
REQ-022 CHECK, zero area (op_width==0 or op_height==0): SHALL go to FINISH with no writes.
REQ-023 CHECK, out of bounds (X1+op_width > SCREEN_W, computed 10-bit, or Y1+op_height > SCREEN_H, computed 9-bit): SHALL pulse error for one cycle, perform no writes, and return to IDLE.
REQ-024 CHECK, otherwise: SHALL load cur_x=X1, cur_y=Y1 and go to FILL.
REQ-025 In FILL, fb_we SHALL be 1 with fb_x=cur_x, fb_y=cur_y, fb_data=latched fill_value.
REQ-026 Writes SHALL occur in raster order, x fastest.
REQ-027 A write is accepted only on a cycle with fb_we=1 and fb_ready=1; cur_x/cur_y SHALL advance only on acceptance.
REQ-028 While fb_ready=0, fb_x, fb_y and fb_data SHALL hold stable.
REQ-029 When cur_x reaches X1+op_width-1, the next accepted write SHALL set cur_x=X1 and cur_y=cur_y+1.
REQ-030 The write accepted at (X1+op_width-1, Y1+op_height-1) SHALL move to FINISH.
REQ-031 Exactly op_width*op_height writes SHALL be accepted per valid command.
REQ-032 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-033 With fb_ready held 1, the first fb_we SHALL appear 2 cycles after the start_fill cycle, and done SHALL appear 1 cycle after the last accepted write.
REQ-034 fb_we SHALL be 0 in every state other than FILL.
REQ-035 A command SHALL be accepted again in the cycle immediately after returning to IDLE.

Reset
REQ-036 While reset=1, the state SHALL be IDLE and fb_we, busy, done and error SHALL be 0.
REQ-037 While reset=1, fb_x, fb_y and fb_data SHALL be 0.
REQ-038 Reset mid-FILL SHALL abort the command in the next cycle, with no further writes and no done pulse.
REQ-039 start_fill asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-040 Basic fill: X1=10, Y1=5, width=3, height=2, fill_value=1, fb_ready=1 -> six writes (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), data 1, done 1 cycle after the last write.
REQ-041 Backpressure: same command with fb_ready toggling 0/1 each cycle -> the same six writes, each held stable while fb_ready=0, no write duplicated or skipped.
REQ-042 Bounds at limit: X1=319, Y1=199, width=1, height=1 -> one write at (319,199), then done.
REQ-043 Bounds exceeded: X1=318, width=3 -> error pulse, zero writes, no done.
REQ-044 Zero area, and start while busy: width=0 -> done with no writes and no error; a second start_fill during a FILL -> ignored, and the write count matches the first command only.
REQ-045 Reset mid-operation: reset asserted after 2 of 6 writes -> fb_we=0 and busy=0 from the next cycle, no done, and a new command then completes normally.
